// File: rtl/ucode_store.sv
// Microprogram control store: 1-cycle fetch port for the CPU while running,
// byte-serial microcode loader (MSB first, 3 bytes per word) while halted.
module ucode_store #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_byte,
  input  logic              ld_valid,
  input  logic              ld_end,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_err,
  output logic              ld_wrap,
  output logic [ADDR_W:0]   ld_count
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_B0     = 3'd1,
    S_B1     = 3'd2,
    S_B2     = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  state_t              state, state_n;
  logic                done_set, err_set;
  logic [ADDR_W-1:0]   ptr;
  logic [WORD_W-1:0]   word_p0;
  logic [WORD_W-1:0]   mem [0:DEPTH-1];

  // Count stops at DEPTH: the top bit is only ever set at the saturation value.
  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] c);
    return c[ADDR_W] ? c : c + 1'b1;
  endfunction

  // Fetch stage: word appears one cycle after the request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (run && rd_en) begin
      rd_data  <= mem[rd_addr];
      rd_valid <= 1'b1;
    end else begin
      rd_valid <= 1'b0;
    end
  end

  // Loader FSM state register and registered status pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      ld_done <= 1'b0;
      ld_err  <= 1'b0;
    end else begin
      state   <= state_n;
      ld_done <= done_set;
      ld_err  <= err_set;
    end
  end

  // run=1 outside IDLE means the CPU resumed mid-session: abort the load.
  always_comb begin
    state_n  = state;
    done_set = 1'b0;
    err_set  = 1'b0;
    case (state)
      S_IDLE: begin
        if (ld_start && !run) state_n = S_B0;
      end
      S_B0: begin
        if (run) begin
          state_n = S_IDLE;
          err_set = 1'b1;
        end else if (ld_end) begin
          state_n  = S_IDLE;
          done_set = 1'b1;
        end else if (ld_valid) begin
          state_n = S_B1;
        end
      end
      S_B1: begin
        if (run || ld_end) begin
          state_n = S_IDLE;
          err_set = 1'b1;
        end else if (ld_valid) begin
          state_n = S_B2;
        end
      end
      S_B2: begin
        if (run || ld_end) begin
          state_n = S_IDLE;
          err_set = 1'b1;
        end else if (ld_valid) begin
          state_n = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (run) begin
          state_n = S_IDLE;
          err_set = 1'b1;
        end else if (ld_end) begin
          state_n  = S_IDLE;
          done_set = 1'b1;
        end else begin
          state_n = S_B0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    ld_ready = 1'b0;
    case (state)
      S_B0, S_B1, S_B2: ld_ready = 1'b1;
      default:          ld_ready = 1'b0;
    endcase
  end

  // Session bookkeeping: pointer, committed-word count, wrap flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr      <= '0;
      ld_count <= '0;
      ld_wrap  <= 1'b0;
    end else if (state == S_IDLE && ld_start && !run) begin
      ptr      <= ld_addr;
      ld_count <= '0;
      ld_wrap  <= 1'b0;
    end else if (state == S_COMMIT) begin
      ptr      <= ptr + 1'b1;
      ld_count <= sat_inc(ld_count);
      if (ptr == {ADDR_W{1'b1}}) ld_wrap <= 1'b1;
    end
  end

  // Byte assembly stage: MSB first; a byte coinciding with ld_end is dropped.
  always_ff @(posedge clk) begin
    if (ld_valid && !ld_end && !run) begin
      case (state)
        S_B0:    word_p0[WORD_W-1 -: 8] <= ld_byte;
        S_B1:    word_p0[WORD_W-9 -: 8] <= ld_byte;
        S_B2:    word_p0[7:0]           <= ld_byte;
        default: ;
      endcase
    end
  end

  // Store array is never cleared; a COMMIT still writes even if run rises.
  always_ff @(posedge clk) begin
    if (rst && state == S_COMMIT) mem[ptr] <= word_p0;
  end

endmodule

// File: tb/tb_ucode_store.sv
// Directed bench for ucode_store: load sessions, fetch latency, wrap,
// abort paths, ld_end/ld_valid priority and reset persistence.
module tb_ucode_store;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [23:0] rd_data;
  logic        rd_valid;
  logic        ld_start;
  logic [7:0]  ld_addr;
  logic [7:0]  ld_byte;
  logic        ld_valid;
  logic        ld_end;
  logic        ld_ready;
  logic        ld_done;
  logic        ld_err;
  logic        ld_wrap;
  logic [8:0]  ld_count;

  int ncmp  = 0;
  int nfail = 0;

  ucode_store #(.ADDR_W(8), .WORD_W(24)) dut (
    .clk(clk), .rst(rst), .run(run),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .ld_start(ld_start), .ld_addr(ld_addr), .ld_byte(ld_byte),
    .ld_valid(ld_valid), .ld_end(ld_end), .ld_ready(ld_ready),
    .ld_done(ld_done), .ld_err(ld_err), .ld_wrap(ld_wrap), .ld_count(ld_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [7:0] a);
    run = 1'b0; ld_start = 1'b1; ld_addr = a;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    ld_valid = 1'b1; ld_byte = b;
    tick();
    ld_valid = 1'b0;
  endtask

  // Three bytes then the COMMIT cycle, optionally closing the session there.
  task automatic load_word(input logic [23:0] w, input logic fin);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
    ld_end = fin;
    tick();
    ld_end = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [7:0] a, input logic [23:0] exp);
    run = 1'b1; rd_en = 1'b1; rd_addr = a;
    tick();
    chk({tag, "_data"}, {8'h0, rd_data}, {8'h0, exp});
    chk({tag, "_valid"}, {31'h0, rd_valid}, 32'h1);
    rd_en = 1'b0; run = 1'b0;
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; rd_en = 1'b0; rd_addr = '0;
    ld_start = 1'b0; ld_addr = '0; ld_byte = '0; ld_valid = 1'b0; ld_end = 1'b0;
    tick(); tick();
    chk("rst_rd_data", {8'h0, rd_data}, 32'h0);
    chk("rst_flags", {27'h0, rd_valid, ld_ready, ld_done, ld_err, ld_wrap}, 32'h0);
    chk("rst_count", {23'h0, ld_count}, 32'h0);
    rst = 1'b1;
    tick();

    // Single word at 0x10 closed during COMMIT.
    start(8'h10);
    chk("b0_ready", {31'h0, ld_ready}, 32'h1);
    load_word(24'h123456, 1'b1);
    chk("w1_done", {31'h0, ld_done}, 32'h1);
    chk("w1_err", {31'h0, ld_err}, 32'h0);
    chk("w1_count", {23'h0, ld_count}, 32'h1);
    chk("w1_ready_idle", {31'h0, ld_ready}, 32'h0);
    tick();
    chk("w1_done_pulse", {31'h0, ld_done}, 32'h0);
    fetch("w1_fetch", 8'h10, 24'h123456);

    // Two words, back-to-back fetches with 1-cycle latency.
    start(8'h10);
    load_word(24'hA0B0C0, 1'b0);
    load_word(24'h0F00FF, 1'b1);
    chk("w2_count", {23'h0, ld_count}, 32'h2);
    run = 1'b1; rd_en = 1'b1; rd_addr = 8'h10;
    tick();
    rd_addr = 8'h11;
    chk("f10_data", {8'h0, rd_data}, 32'hA0B0C0);
    chk("f10_valid", {31'h0, rd_valid}, 32'h1);
    tick();
    chk("f11_data", {8'h0, rd_data}, 32'h0F00FF);
    chk("f11_valid", {31'h0, rd_valid}, 32'h1);
    rd_en = 1'b0;
    tick();
    chk("idle_hold_data", {8'h0, rd_data}, 32'h0F00FF);
    chk("idle_valid", {31'h0, rd_valid}, 32'h0);
    run = 1'b0; rd_en = 1'b1; rd_addr = 8'h10;
    tick();
    chk("halt_valid", {31'h0, rd_valid}, 32'h0);
    chk("halt_hold_data", {8'h0, rd_data}, 32'h0F00FF);
    rd_en = 1'b0;

    // Pointer wrap from 0xFF to 0x00.
    start(8'hFF);
    chk("wrap_clear", {31'h0, ld_wrap}, 32'h0);
    load_word(24'h111111, 1'b0);
    chk("wrap_set", {31'h0, ld_wrap}, 32'h1);
    load_word(24'h222222, 1'b1);
    chk("wrap_count", {23'h0, ld_count}, 32'h2);
    chk("wrap_sticky", {31'h0, ld_wrap}, 32'h1);
    fetch("wrap_ff", 8'hFF, 24'h111111);
    fetch("wrap_00", 8'h00, 24'h222222);

    // Partial word aborted by ld_end.
    start(8'h10);
    chk("restart_wrap_clr", {31'h0, ld_wrap}, 32'h0);
    send_byte(8'h99);
    send_byte(8'h88);
    ld_end = 1'b1;
    tick();
    ld_end = 1'b0;
    chk("pend_err", {31'h0, ld_err}, 32'h1);
    chk("pend_done", {31'h0, ld_done}, 32'h0);
    chk("pend_idle", {31'h0, ld_ready}, 32'h0);
    chk("pend_count", {23'h0, ld_count}, 32'h0);
    tick();
    chk("pend_err_pulse", {31'h0, ld_err}, 32'h0);
    fetch("pend_keep", 8'h10, 24'hA0B0C0);

    // Partial word aborted by run rising.
    start(8'h11);
    send_byte(8'h77);
    send_byte(8'h66);
    run = 1'b1;
    tick();
    chk("prun_err", {31'h0, ld_err}, 32'h1);
    chk("prun_idle", {31'h0, ld_ready}, 32'h0);
    fetch("prun_keep", 8'h11, 24'h0F00FF);

    // ld_valid and ld_end together in B0: byte dropped, clean close.
    start(8'h20);
    load_word(24'h123ABC, 1'b0);
    chk("b0pri_pre_count", {23'h0, ld_count}, 32'h1);
    ld_valid = 1'b1; ld_byte = 8'h55; ld_end = 1'b1;
    tick();
    ld_valid = 1'b0; ld_end = 1'b0;
    chk("b0pri_done", {31'h0, ld_done}, 32'h1);
    chk("b0pri_err", {31'h0, ld_err}, 32'h0);
    chk("b0pri_count", {23'h0, ld_count}, 32'h1);
    chk("b0pri_idle", {31'h0, ld_ready}, 32'h0);
    fetch("b0pri_word", 8'h20, 24'h123ABC);

    // Memory survives reset; outputs forced to zero while in reset.
    start(8'h30);
    load_word(24'hDEADBE, 1'b1);
    fetch("pre_rst", 8'h30, 24'hDEADBE);
    rst = 1'b0; run = 1'b1; rd_en = 1'b1; rd_addr = 8'h30;
    tick();
    chk("inrst_rd_data", {8'h0, rd_data}, 32'h0);
    chk("inrst_flags", {27'h0, rd_valid, ld_ready, ld_done, ld_err, ld_wrap}, 32'h0);
    chk("inrst_count", {23'h0, ld_count}, 32'h0);
    rst = 1'b1; rd_en = 1'b0; run = 1'b0;
    fetch("post_rst", 8'h30, 24'hDEADBE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/ucode_store.md
Name: ucode_store

Overview:
- Microprogram control store: the responder on the CPU's microinstruction fetch interface.
- Returns one 24-bit microinstruction per requested 8-bit micro-address while the CPU runs.
- While the CPU is halted (run=0), a byte-serial loader writes microcode into the store.
- Sits between the host/debug loader and the CPU datapath's addr_rom/in_rom pins.

Parameters:
- ADDR_W, 8, micro-address width; depth = 2^ADDR_W words.
- WORD_W, 24, microinstruction width; fixed at 3 bytes.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-low.
- run  in  1  1 = CPU fetch mode; 0 = load mode.
- rd_en  in  1  fetch request strobe from the CPU (derived from its fetch clock).
- rd_addr  in  ADDR_W  micro-address from the CPU uPC.
- rd_data  out  WORD_W  microinstruction to the CPU.
- rd_valid  out  1  rd_data holds a word fetched on the previous cycle.
- ld_start  in  1  begin a load session at ld_addr.
- ld_addr  in  ADDR_W  load start address; sampled with ld_start.
- ld_byte  in  8  load data byte.
- ld_valid  in  1  ld_byte is valid; accepted when ld_ready=1.
- ld_end  in  1  terminate the load session.
- ld_ready  out  1  loader can accept a byte this cycle.
- ld_done  out  1  one-cycle pulse: session closed cleanly.
- ld_err  out  1  one-cycle pulse: session aborted, partial word discarded.
- ld_wrap  out  1  sticky: the load pointer wrapped past the top address; cleared by ld_start.
- ld_count  out  ADDR_W+1  words committed in the current session.

Behaviour:
- Reset (rst=0 at an edge):
  - rd_data=0, rd_valid=0, ld_ready=0, ld_done=0, ld_err=0, ld_wrap=0, ld_count=0.
  - Load FSM goes to IDLE and the pointer to 0.
  - Memory array is not cleared; its contents persist across rst.
  - Reset during a load discards any partial word with no ld_err pulse.
- Fetch path, active only when run=1:
  - rd_en=1 at edge N: rd_data = mem[rd_addr] and rd_valid=1 after edge N (1-cycle latency).
  - rd_en=0: rd_data holds its value and rd_valid=0.
  - run=0: rd_valid=0 and rd_data holds.
- Load FSM states: IDLE, B0, B1, B2, COMMIT.
  - IDLE: ld_ready=0. ld_start=1 with run=0 → B0; ptr=ld_addr, ld_count=0, ld_wrap=0. ld_start while run=1 is ignored.
  - B0: ld_ready=1. ld_valid → capture word[23:16], go to B1. ld_end → IDLE with ld_done pulse. ld_end has priority over ld_valid in the same cycle; that byte is dropped.
  - B1: ld_ready=1. ld_valid → capture word[15:8], go to B2.
  - B2: ld_ready=1. ld_valid → capture word[7:0], go to COMMIT.
  - COMMIT: ld_ready=0. Write mem[ptr]=assembled word, ptr=ptr+1 (mod 2^ADDR_W), ld_count+1. Then go to B0, or to IDLE with ld_done if ld_end=1 during COMMIT.
  - Wrap: when ptr goes from 2^ADDR_W-1 to 0, set ld_wrap=1 and continue loading.
  - ld_count saturates at 2^ADDR_W.
  - ld_end in B1 or B2 → IDLE, partial word discarded, ld_err pulse.
  - run rising to 1 in any non-IDLE state → IDLE, ld_err pulse. A COMMIT in that same cycle still completes its write.
  - ld_start outside IDLE is ignored.
- Reads and writes are mutually exclusive by run; no read-during-write hazard exists.
- Byte order is most-significant first, so byte 0 carries the ALU op and high register-select fields.

Test Plan:
- Reset, then ld_start at addr 0x10, bytes 0x12,0x34,0x56, ld_end → mem[0x10]=0x123456, ld_count=1, ld_done pulses once, ld_err=0.
- Load 0xA0B0C0 at 0x10 and 0x0F00FF at 0x11, then run=1 with rd_en and rd_addr 0x10 then 0x11 → rd_data=0xA0B0C0 then 0x0F00FF, each one cycle after its request, rd_valid=1 both cycles.
- ld_start at 0xFF, load two words → words land at 0xFF and 0x00, ld_wrap=1, ld_count=2.
- Send 2 bytes then ld_end → ld_err pulses, target location unchanged, FSM returns to IDLE. Repeat the partial load, but raise run=1 instead of ld_end → same result.
- ld_valid and ld_end together in B0 → byte dropped, ld_done pulses, ld_count unchanged.
- Load a word, pulse rst for 1 cycle, then fetch it → original data returned; all outputs were 0 during reset.
